// File: rtl/pc_seq.sv
// pc_seq: program counter sequencer.
// Selects the next PC (sequential, branch/jal, jalr) and checks its alignment.
// Applies trap/xret redirects and retires or faults the current instruction.
// Handles debug halt/resume together with the saved debug PC (dpc).
module pc_seq #(
    parameter int               Width        = 32,
    parameter logic [Width-1:0] ResetVec     = '0,
    parameter int               CompressedEn = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             branch,
    input  logic             jal,
    input  logic             jalr,
    input  logic             take,
    input  logic             is16,
    input  logic [Width-1:0] rs,
    input  logic [Width-1:0] imm,
    input  logic             trap,
    input  logic [Width-1:0] tvec,
    input  logic             xret,
    input  logic [Width-1:0] epc,
    input  logic             halt_req,
    input  logic             resume_req,
    input  logic             dpc_we,
    input  logic [Width-1:0] dpc_wdata,
    output logic [Width-1:0] pc,
    output logic [Width-1:0] next_pc,
    output logic             ialign,
    output logic             misalign,
    output logic [Width-1:0] badaddr,
    output logic             halted,
    output logic [Width-1:0] dpc,
    output logic             retired
);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    logic [0:0]       state;
    logic [Width-1:0] seq_inc;
    logic [Width-1:0] seq_pc;
    logic [Width-1:0] jalr_sum;
    logic [Width-1:0] dpc_wr;
    logic [Width-1:0] ev_pc;
    logic             redirect;
    logic             fault;
    logic             commit;

    // Sequential step and control-transfer target selection.
    always_comb begin
        seq_inc  = (CompressedEn != 0 && is16) ? Width'(2) : Width'(4);
        seq_pc   = pc + seq_inc;
        jalr_sum = rs + imm;
        if ((branch && take) || jal)
            next_pc = pc + imm;
        else if (jalr)
            next_pc = {jalr_sum[Width-1:1], 1'b0};
        else
            next_pc = seq_pc;
    end

    // Alignment check against IALIGN, and the aligned debugger write value.
    always_comb begin
        if (CompressedEn != 0) begin
            ialign = next_pc[0];
            dpc_wr = {dpc_wdata[Width-1:1], 1'b0};
        end else begin
            ialign = |next_pc[1:0];
            dpc_wr = {dpc_wdata[Width-1:2], 2'b00};
        end
    end

    // Resolve this cycle's RUN event by priority: trap > xret > fault > commit.
    // ev_pc is the post-event PC; a halt in the same cycle captures it into dpc.
    always_comb begin
        redirect = trap || xret;
        fault    = !redirect && advance && ialign;
        commit   = !redirect && advance && !ialign;
        if (trap)
            ev_pc = tvec;
        else if (xret)
            ev_pc = epc;
        else if (commit)
            ev_pc = next_pc;
        else
            ev_pc = pc;
    end

    // PC, debug state and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= ResetVec;
            dpc      <= ResetVec;
            badaddr  <= '0;
            misalign <= 1'b0;
            retired  <= 1'b0;
        end else begin
            misalign <= 1'b0;
            retired  <= 1'b0;
            case (state)
                RUN: begin
                    pc       <= ev_pc;
                    misalign <= fault;
                    retired  <= commit;
                    if (fault)
                        badaddr <= next_pc;
                    if (halt_req) begin
                        dpc   <= ev_pc;
                        state <= HALTED;
                    end
                end
                HALTED: begin
                    if (dpc_we)
                        dpc <= dpc_wr;
                    // A write in the same cycle as resume wins as the target.
                    if (resume_req) begin
                        pc    <= dpc_we ? dpc_wr : dpc;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign halted = (state == HALTED);

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: scoreboard bench for pc_seq.
// Two instances share the same stimulus: u0 with CompressedEn=1, u1 with
// CompressedEn=0, both with ResetVec=0x100. The driver pushes model-predicted
// results into a queue; the monitor pops them and compares against the DUTs.
module tb_pc_seq;

    typedef struct packed {
        logic        rst_n, advance, branch, jal, jalr, take, is16;
        logic [31:0] rs, imm;
        logic        trap;
        logic [31:0] tvec;
        logic        xret;
        logic [31:0] epc;
        logic        halt_req, resume_req, dpc_we;
        logic [31:0] dpc_wdata;
    } in_t;

    typedef struct packed {
        logic [31:0] pc, dpc, badaddr;
        logic        halted, mis, ret;
    } st_t;

    typedef struct packed {
        logic            rst;
        logic [1:0][31:0] npc;
        logic [1:0]      ial;
        st_t  [1:0]      post;
    } rec_t;

    localparam logic [31:0] RV = 32'h100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t  cur;
    rec_t q[$];
    st_t  ms [2];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] pc_o [2], npc_o [2], bad_o [2], dpc_o [2];
    logic        ial_o [2], mis_o [2], hlt_o [2], ret_o [2];

    pc_seq #(.Width(32), .ResetVec(RV), .CompressedEn(1)) u0 (
        .clk(clk), .rst_n(cur.rst_n), .advance(cur.advance), .branch(cur.branch),
        .jal(cur.jal), .jalr(cur.jalr), .take(cur.take), .is16(cur.is16),
        .rs(cur.rs), .imm(cur.imm), .trap(cur.trap), .tvec(cur.tvec),
        .xret(cur.xret), .epc(cur.epc), .halt_req(cur.halt_req),
        .resume_req(cur.resume_req), .dpc_we(cur.dpc_we), .dpc_wdata(cur.dpc_wdata),
        .pc(pc_o[0]), .next_pc(npc_o[0]), .ialign(ial_o[0]), .misalign(mis_o[0]),
        .badaddr(bad_o[0]), .halted(hlt_o[0]), .dpc(dpc_o[0]), .retired(ret_o[0]));

    pc_seq #(.Width(32), .ResetVec(RV), .CompressedEn(0)) u1 (
        .clk(clk), .rst_n(cur.rst_n), .advance(cur.advance), .branch(cur.branch),
        .jal(cur.jal), .jalr(cur.jalr), .take(cur.take), .is16(cur.is16),
        .rs(cur.rs), .imm(cur.imm), .trap(cur.trap), .tvec(cur.tvec),
        .xret(cur.xret), .epc(cur.epc), .halt_req(cur.halt_req),
        .resume_req(cur.resume_req), .dpc_we(cur.dpc_we), .dpc_wdata(cur.dpc_wdata),
        .pc(pc_o[1]), .next_pc(npc_o[1]), .ialign(ial_o[1]), .misalign(mis_o[1]),
        .badaddr(bad_o[1]), .halted(hlt_o[1]), .dpc(dpc_o[1]), .retired(ret_o[1]));

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_next(logic [31:0] pc, in_t i, bit ce);
        logic [31:0] t;
        if ((i.branch && i.take) || i.jal) return pc + i.imm;
        if (i.jalr) begin
            t = i.rs + i.imm;
            return t & ~32'h1;
        end
        return pc + ((ce && i.is16) ? 32'd2 : 32'd4);
    endfunction

    function automatic bit m_bad(logic [31:0] a, bit ce);
        return ce ? (a % 2 != 0) : (a % 4 != 0);
    endfunction

    function automatic st_t m_reset();
        st_t s;
        s.pc = RV; s.dpc = RV; s.badaddr = 0; s.halted = 0; s.mis = 0; s.ret = 0;
        return s;
    endfunction

    function automatic st_t m_step(st_t s, in_t i, bit ce);
        st_t n = s;
        logic [31:0] np = m_next(s.pc, i, ce);
        logic [31:0] wd = ce ? (i.dpc_wdata & ~32'h1) : (i.dpc_wdata & ~32'h3);
        n.mis = 0; n.ret = 0;
        if (!i.rst_n) return m_reset();
        if (!s.halted) begin
            if (i.trap) n.pc = i.tvec;
            else if (i.xret) n.pc = i.epc;
            else if (i.advance && m_bad(np, ce)) begin n.badaddr = np; n.mis = 1; end
            else if (i.advance) begin n.pc = np; n.ret = 1; end
            if (i.halt_req) begin n.halted = 1; n.dpc = n.pc; end
        end else begin
            if (i.dpc_we) n.dpc = wd;
            if (i.resume_req) begin n.pc = n.dpc; n.halted = 0; end
        end
        return n;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(int d, st_t e);
        chk($sformatf("u%0d pc", d),       pc_o[d],  e.pc);
        chk($sformatf("u%0d dpc", d),      dpc_o[d], e.dpc);
        chk($sformatf("u%0d badaddr", d),  bad_o[d], e.badaddr);
        chk($sformatf("u%0d halted", d),   32'(hlt_o[d]), 32'(e.halted));
        chk($sformatf("u%0d misalign", d), 32'(mis_o[d]), 32'(e.mis));
        chk($sformatf("u%0d retired", d),  32'(ret_o[d]), 32'(e.ret));
    endtask

    // Monitor: comb outputs shortly after the inputs settle, state after the edge.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() != 0) begin
                r = q.pop_front();
                for (int d = 0; d < 2; d++) begin
                    if (r.rst) chk_state(d, r.post[d]);
                    else begin
                        chk($sformatf("u%0d next_pc", d), npc_o[d], r.npc[d]);
                        chk($sformatf("u%0d ialign", d), 32'(ial_o[d]), 32'(r.ial[d]));
                    end
                end
                @(posedge clk);
                #1;
                for (int d = 0; d < 2; d++) chk_state(d, r.post[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic in_t idle();
        in_t i = '0;
        i.rst_n = 1'b1;
        return i;
    endfunction

    task automatic cyc(in_t i);
        rec_t r;
        @(negedge clk);
        cur = i;
        r.rst = !i.rst_n;
        for (int d = 0; d < 2; d++) begin
            r.npc[d] = m_next(ms[d].pc, i, d == 0);
            r.ial[d] = m_bad(r.npc[d], d == 0);
            ms[d] = m_step(ms[d], i, d == 0);
            r.post[d] = ms[d];
        end
        q.push_back(r);
    endtask

    initial begin
        in_t i;
        cur = '0;
        ms[0] = m_reset();
        ms[1] = m_reset();

        i = idle(); i.rst_n = 0; cyc(i); cyc(i);
        // sequential flow: u0 0x102 then 0x106; u1 ignores is16
        i = idle(); i.advance = 1; i.is16 = 1; cyc(i);
        i.is16 = 0; cyc(i);
        // misaligned branch from 0x200 (faults only on u1)
        i = idle(); i.trap = 1; i.tvec = 32'h200; cyc(i);
        i = idle(); i.advance = 1; i.branch = 1; i.take = 1; i.imm = 32'h6; cyc(i);
        cyc(idle());
        // jalr clears bit0
        i = idle(); i.advance = 1; i.jalr = 1; i.rs = 32'h1001; i.imm = 32'h4; cyc(i);
        // trap beats xret and advance
        i = idle(); i.trap = 1; i.xret = 1; i.advance = 1; i.tvec = 32'h80; i.epc = 32'h500; cyc(i);
        // debug halt with advance to 0x300, dpc write, resume
        i = idle(); i.trap = 1; i.tvec = 32'h2FC; cyc(i);
        i = idle(); i.advance = 1; i.halt_req = 1; cyc(i);
        i = idle(); i.dpc_we = 1; i.dpc_wdata = 32'h403; cyc(i);
        i = idle(); i.advance = 1; i.trap = 1; i.tvec = 32'h44; i.halt_req = 1; cyc(i);
        i = idle(); i.resume_req = 1; cyc(i);
        // dpc_we ignored in RUN
        i = idle(); i.dpc_we = 1; i.dpc_wdata = 32'h999; cyc(i);
        // wrap
        i = idle(); i.trap = 1; i.tvec = 32'hFFFF_FFFC; cyc(i);
        i = idle(); i.advance = 1; cyc(i);
        // resume together with dpc write
        i = idle(); i.halt_req = 1; cyc(i);
        i = idle(); i.resume_req = 1; i.dpc_we = 1; i.dpc_wdata = 32'h777; cyc(i);
        // reset while halted
        i = idle(); i.halt_req = 1; cyc(i);
        i = idle(); i.rst_n = 0; i.resume_req = 1; i.advance = 1; cyc(i);
        i = idle(); i.advance = 1; cyc(i);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            i.rst_n      = ($urandom_range(0, 49) != 0);
            i.advance    = $urandom_range(0, 1);
            i.branch     = ($urandom_range(0, 3) == 0);
            i.jal        = ($urandom_range(0, 3) == 0);
            i.jalr       = ($urandom_range(0, 3) == 0);
            i.take       = $urandom_range(0, 1);
            i.is16       = $urandom_range(0, 1);
            i.rs         = $urandom;
            i.imm        = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63)) - 32'd32;
            i.trap       = ($urandom_range(0, 15) == 0);
            i.tvec       = $urandom;
            i.xret       = ($urandom_range(0, 15) == 0);
            i.epc        = $urandom;
            i.halt_req   = ($urandom_range(0, 15) == 0);
            i.resume_req = ($urandom_range(0, 3) == 0);
            i.dpc_we     = ($urandom_range(0, 3) == 0);
            i.dpc_wdata  = $urandom;
            cyc(i);
        end
        cyc(idle());

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter Width, default 32, meaning the PC and operand width in bits.
REQ-002 SHALL have parameter ResetVec, default 0, meaning the PC value after reset.
REQ-003 SHALL have parameter CompressedEn, default 0, meaning IALIGN=16 when 1 and IALIGN=32 when 0.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port advance  in  1  the current instruction completes this cycle.
REQ-007 SHALL have ports branch, jal, jalr, take  in  1 each  control-transfer class and branch outcome.
REQ-008 SHALL have port is16  in  1  the current instruction is 16-bit; ignored when CompressedEn=0.
REQ-009 SHALL have ports rs, imm  in  Width each  jalr base register value and immediate.
REQ-010 SHALL have ports trap  in  1 and tvec  in  Width  exception redirect request and its target.
REQ-011 SHALL have ports xret  in  1 and epc  in  Width  return-from-trap request and its target.
REQ-012 SHALL have ports halt_req, resume_req  in  1 each  debug halt and resume requests.
REQ-013 SHALL have ports dpc_we  in  1 and dpc_wdata  in  Width  debugger write to dpc.
REQ-014 SHALL have port pc  out  Width  the registered current PC.
REQ-015 SHALL have port next_pc  out  Width  the combinational candidate next PC.
REQ-016 SHALL have port ialign  out  1  combinational: next_pc is misaligned.
REQ-017 SHALL have ports misalign  out  1 and badaddr  out  Width  registered one-cycle fault pulse and the captured faulting target.
REQ-018 SHALL have ports halted  out  1 and dpc  out  Width  debug state and saved debug PC.
REQ-019 SHALL have port retired  out  1  registered one-cycle pulse per committed instruction.

Function
REQ-020 SHALL compute seq = pc + 2 when CompressedEn=1 and is16=1, and pc + 4 otherwise; all sums are modulo 2^Width.
REQ-021 SHALL compute next_pc = pc+imm when (branch&take) or jal; otherwise (rs+imm) with bit0 cleared when jalr; otherwise seq.
REQ-022 SHALL drive ialign = next_pc[0] when CompressedEn=1, and ialign = (next_pc[1:0] != 0) when CompressedEn=0.
REQ-023 SHALL implement a two-state FSM with states RUN and HALTED.
REQ-024 SHALL apply one event per cycle in RUN, in priority order trap > xret > fault > commit.
REQ-025 SHALL, on trap in RUN, load pc <= tvec, regardless of advance.
REQ-026 SHALL, on xret in RUN without trap, load pc <= epc.
REQ-027 SHALL, on advance with ialign=1 and neither trap nor xret, leave pc unchanged, load badaddr <= next_pc, and pulse misalign the next cycle.
REQ-028 SHALL, on advance with ialign=0 and neither trap nor xret, load pc <= next_pc and pulse retired the next cycle.
REQ-029 SHALL hold pc when advance=0 and neither trap nor xret is asserted.
REQ-030 SHALL, on halt_req in RUN, take the halt in the same cycle as any event above: dpc <= the pc value that results from that cycle's event, pc <= that same value, FSM -> HALTED.
REQ-031 SHALL, in HALTED, ignore advance, trap, xret and halt_req; pc, misalign and retired hold or stay low.
REQ-032 SHALL, on dpc_we in HALTED, load dpc <= dpc_wdata with bit0 cleared; bits[1:0] are cleared when CompressedEn=0.
REQ-033 SHALL ignore dpc_we in RUN.
REQ-034 SHALL, on resume_req in HALTED, load pc <= dpc and move the FSM -> RUN.
REQ-035 SHALL, when resume_req and dpc_we occur in the same cycle, use dpc_wdata (aligned) as the resume target.
REQ-036 SHALL drive halted = 1 exactly while the FSM is in HALTED.

Reset
REQ-037 SHALL, while rst_n=0, asynchronously force pc=ResetVec, dpc=ResetVec, badaddr=0, misalign=0, retired=0 and state=RUN.
REQ-038 SHALL, on reset asserted mid-operation (including while HALTED), discard pending requests, and resume normal operation on the first rising clk edge after rst_n rises.

Verification
REQ-039 SHALL cover sequential flow: ResetVec=0x100, CompressedEn=1, advance with is16=1 then is16=0 -> pc=0x102, then 0x106; retired pulses twice.
REQ-040 SHALL cover a misaligned branch: CompressedEn=0, pc=0x200, branch=take=1, imm=0x6 -> ialign=1, pc stays 0x200, badaddr=0x206, misalign one cycle.
REQ-041 SHALL cover jalr: rs=0x1001, imm=0x4 -> pc=0x1004, bit0 cleared, no misalign.
REQ-042 SHALL cover priority: trap=1, xret=1, advance=1, tvec=0x80 -> pc=0x80, no retired pulse.
REQ-043 SHALL cover debug: halt_req with advance to 0x300 -> halted=1, dpc=0x300; dpc_we 0x403 -> dpc=0x400 (CompressedEn=0); resume_req -> pc=0x400, halted=0.
REQ-044 SHALL cover wrap and reset: pc=0xFFFFFFFC, advance -> pc=0; rst_n low while HALTED -> pc=ResetVec, halted=0 immediately.
